// File: rtl/ad9970_sync_decoder_if.sv
// Parallel-word link between the AD9970 LVDS word aligner and the sync decoder,
// together with the decoder's configuration words and its regenerated video outputs.
interface ad9970_sync_decoder_if #(
  parameter int unsigned PIX_WIDTH = 14,
  parameter int unsigned CNT_WIDTH = 13
);
  logic                 i_data_valid;
  logic [15:0]          iv_data;
  logic [15:0]          iv_sync_word0;
  logic [15:0]          iv_sync_word1;
  logic [15:0]          iv_sync_word2;
  logic [15:0]          iv_code_sof;
  logic [15:0]          iv_code_sol;
  logic [15:0]          iv_code_eol;
  logic [15:0]          iv_code_eof;
  logic [CNT_WIDTH-1:0] iv_max_pix;
  logic                 o_fval;
  logic                 o_lval;
  logic                 o_pix_valid;
  logic [PIX_WIDTH-1:0] ov_pix_data;
  logic [CNT_WIDTH-1:0] ov_line_pix_cnt;
  logic                 o_sync_err;

  modport master (
    output i_data_valid, iv_data, iv_sync_word0, iv_sync_word1, iv_sync_word2,
           iv_code_sof, iv_code_sol, iv_code_eol, iv_code_eof, iv_max_pix,
    input  o_fval, o_lval, o_pix_valid, ov_pix_data, ov_line_pix_cnt, o_sync_err
  );

  modport slave (
    input  i_data_valid, iv_data, iv_sync_word0, iv_sync_word1, iv_sync_word2,
           iv_code_sof, iv_code_sol, iv_code_eol, iv_code_eof, iv_max_pix,
    output o_fval, o_lval, o_pix_valid, ov_pix_data, ov_line_pix_cnt, o_sync_err
  );
endinterface

// File: rtl/ad9970_sync_decoder.sv
// AD9970 embedded-sync decoder: finds preamble+code sequences in the word stream, strips
// them, and regenerates fval/lval/pixel data delayed by four valid words.
module ad9970_sync_decoder #(
  parameter int unsigned PIX_WIDTH = 14,
  parameter int unsigned CNT_WIDTH = 13
) (
  input logic                  clk,
  input logic                  reset,
  ad9970_sync_decoder_if.slave bus
);

  typedef enum logic [2:0] {KNone, KData, KSof, KSol, KEol, KEof} kind_e;
  typedef enum logic [1:0] {StIdle, StLine, StGap} state_e;
  typedef struct packed {
    kind_e       kind;
    logic [15:0] data;
  } entry_t;

  localparam logic [CNT_WIDTH-1:0] CntAll = '1;

  entry_t               dly_q [4];
  entry_t               dly_d [4];
  entry_t               exit_e;
  kind_e                code_kind;
  logic                 preamble_hit;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [PIX_WIDTH-1:0] pix_q, pix_d;
  logic                 fval_q, fval_d;
  logic                 lval_q, lval_d;
  logic                 pix_valid_q, pix_valid_d;
  logic                 err_q, err_d;

  // Words are classified on entry; the FSM acts on them as they leave the delay line, so
  // fval/lval stay aligned with the pixels they qualify.
  always_comb begin
    code_kind = KData;
    if (bus.iv_data == bus.iv_code_sof) begin
      code_kind = KSof;
    end else if (bus.iv_data == bus.iv_code_sol) begin
      code_kind = KSol;
    end else if (bus.iv_data == bus.iv_code_eol) begin
      code_kind = KEol;
    end else if (bus.iv_data == bus.iv_code_eof) begin
      code_kind = KEof;
    end
    preamble_hit = (dly_q[2].kind == KData) && (dly_q[2].data == bus.iv_sync_word0) &&
                   (dly_q[1].kind == KData) && (dly_q[1].data == bus.iv_sync_word1) &&
                   (dly_q[0].kind == KData) && (dly_q[0].data == bus.iv_sync_word2);
  end

  always_comb begin
    dly_d = dly_q;
    if (bus.i_data_valid) begin
      for (int i = 3; i > 0; i--) begin
        dly_d[i] = dly_q[i-1];
      end
      dly_d[0] = '{kind: KData, data: bus.iv_data};
      if (preamble_hit && (code_kind != KData)) begin
        dly_d[0].kind = code_kind;
        dly_d[1].kind = KNone;
        dly_d[2].kind = KNone;
        dly_d[3].kind = KNone;
      end
    end
  end

  assign exit_e = dly_q[3];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_cnt_d  = line_cnt_q;
    pix_d       = pix_q;
    fval_d      = fval_q;
    lval_d      = lval_q;
    pix_valid_d = 1'b0;
    err_d       = 1'b0;
    if (bus.i_data_valid) begin
      lval_d = 1'b0;
      case (state_q)
        StIdle: begin
          if (exit_e.kind == KSof) begin
            state_d = StLine;
            cnt_d   = '0;
          end
        end
        StLine: begin
          case (exit_e.kind)
            KData: begin
              if ((bus.iv_max_pix != '0) && (cnt_q == bus.iv_max_pix)) begin
                err_d   = 1'b1;
                state_d = StGap;
              end else begin
                pix_valid_d = 1'b1;
                lval_d      = 1'b1;
                pix_d       = exit_e.data[PIX_WIDTH-1:0];
                cnt_d       = (cnt_q == CntAll) ? cnt_q : cnt_q + 1'b1;
              end
            end
            KEol: begin
              state_d    = StGap;
              line_cnt_d = cnt_q;
            end
            KEof: begin
              state_d    = StIdle;
              line_cnt_d = cnt_q;
            end
            KSof, KSol: begin
              err_d = 1'b1;
              cnt_d = '0;
            end
            default: ;
          endcase
        end
        StGap: begin
          case (exit_e.kind)
            KSol: begin
              state_d = StLine;
              cnt_d   = '0;
            end
            KSof: begin
              err_d   = 1'b1;
              state_d = StLine;
              cnt_d   = '0;
            end
            KEof:    state_d = StIdle;
            KEol:    err_d   = 1'b1;
            default: ;
          endcase
        end
        default: state_d = StIdle;
      endcase
      fval_d = (state_d != StIdle);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        dly_q[i] <= '{kind: KNone, data: 16'h0000};
      end
      state_q     <= StIdle;
      cnt_q       <= '0;
      line_cnt_q  <= '0;
      pix_q       <= '0;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_cnt_q  <= line_cnt_d;
      pix_q       <= pix_d;
      fval_q      <= fval_d;
      lval_q      <= lval_d;
      pix_valid_q <= pix_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_fval          = fval_q;
  assign bus.o_lval          = lval_q;
  assign bus.o_pix_valid     = pix_valid_q;
  assign bus.ov_pix_data     = pix_q;
  assign bus.ov_line_pix_cnt = line_cnt_q;
  assign bus.o_sync_err      = err_q;

endmodule

// File: tb/tb_ad9970_sync_decoder.sv
// Directed bench for ad9970_sync_decoder: frames, gapped input, partial preambles,
// max-length overflow, line restart, mid-line reset and illegal code placement.
module tb_ad9970_sync_decoder;
  localparam int unsigned PW = 14;
  localparam int unsigned CW = 13;
  localparam logic [15:0] S0    = 16'hFFFF;
  localparam logic [15:0] S1    = 16'h0000;
  localparam logic [15:0] S2    = 16'h0000;
  localparam logic [15:0] C_SOF = 16'h8000;
  localparam logic [15:0] C_SOL = 16'hAB00;
  localparam logic [15:0] C_EOL = 16'h9D00;
  localparam logic [15:0] C_EOF = 16'hB600;
  localparam logic [15:0] FILL  = 16'h0111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ad9970_sync_decoder_if #(.PIX_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  ad9970_sync_decoder #(.PIX_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [PW-1:0] pix_log[$];
  int err_total = 0;
  int gap_bad = 0;
  int lval_bad = 0;
  int fval_hits = 0;
  logic mon_v;

  // Output monitor: logs pixels and pulses, flags pixels from edges without valid input.
  always @(posedge clk) begin
    mon_v = bus.i_data_valid;
    #1;
    if (bus.o_pix_valid) begin
      pix_log.push_back(bus.ov_pix_data);
      if (!mon_v) gap_bad++;
      if (!bus.o_lval) lval_bad++;
    end
    if (bus.o_sync_err) err_total++;
    if (bus.o_fval) fval_hits++;
  end

  task automatic send(input logic [15:0] w, input bit gapped);
    @(negedge clk);
    bus.i_data_valid = 1'b1;
    bus.iv_data      = w;
    @(posedge clk);
    #2;
    if (gapped) begin
      @(negedge clk);
      bus.i_data_valid = 1'b0;
      bus.iv_data      = 16'hDEAD;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pre(input logic [15:0] code, input bit gapped);
    send(S0, gapped);
    send(S1, gapped);
    send(S2, gapped);
    send(code, gapped);
  endtask

  task automatic flush(input bit gapped);
    for (int i = 0; i < 4; i++) send(FILL, gapped);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_data_valid  = 1'b0;
    bus.iv_data       = 16'h0000;
    bus.iv_sync_word0 = S0;
    bus.iv_sync_word1 = S1;
    bus.iv_sync_word2 = S2;
    bus.iv_code_sof   = C_SOF;
    bus.iv_code_sol   = C_SOL;
    bus.iv_code_eol   = C_EOL;
    bus.iv_code_eof   = C_EOF;
    bus.iv_max_pix    = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors += 6;
    if (bus.o_fval !== 1'b0) begin miscompares++; $display("FAIL reset_fval got %b want 0", bus.o_fval); end
    if (bus.o_lval !== 1'b0) begin miscompares++; $display("FAIL reset_lval got %b want 0", bus.o_lval); end
    if (bus.o_pix_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pixv got %b want 0", bus.o_pix_valid); end
    if (bus.ov_pix_data !== '0) begin miscompares++; $display("FAIL reset_pix got %h want 0", bus.ov_pix_data); end
    if (bus.ov_line_pix_cnt !== '0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", bus.ov_line_pix_cnt); end
    if (bus.o_sync_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.o_sync_err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_frame(input bit gapped);
    int base = pix_log.size();
    int e0 = err_total;
    int f0 = fval_hits;
    int g0 = gap_bad;
    int l0 = lval_bad;
    logic [PW-1:0] got;
    pre(C_SOF, gapped);
    for (int i = 1; i <= 10; i++) begin
      send(16'(i), gapped);
      if (i == 4) begin
        vectors++;
        if (pix_log.size() != base) begin
          miscompares++;
          $display("FAIL frame%0d_latency_early got %0d pixels want 0", gapped, pix_log.size() - base);
        end
      end
      if (i == 5) begin
        vectors++;
        if (pix_log.size() != base + 1) begin
          miscompares++;
          $display("FAIL frame%0d_latency got %0d pixels want 1", gapped, pix_log.size() - base);
        end
      end
    end
    pre(C_EOL, gapped);
    pre(C_EOF, gapped);
    flush(gapped);
    vectors++;
    if (pix_log.size() - base != 10) begin
      miscompares++;
      $display("FAIL frame%0d_npix got %0d want 10", gapped, pix_log.size() - base);
    end
    for (int k = 0; k < 10; k++) begin
      got = (base + k < pix_log.size()) ? pix_log[base + k] : 'x;
      vectors++;
      if (got !== PW'(k + 1)) begin
        miscompares++;
        $display("FAIL frame%0d_pix%0d got %h want %h", gapped, k, got, PW'(k + 1));
      end
    end
    vectors += 6;
    if (bus.ov_line_pix_cnt !== CW'(10)) begin miscompares++; $display("FAIL frame%0d_cnt got %0d want 10", gapped, bus.ov_line_pix_cnt); end
    if (fval_hits == f0) begin miscompares++; $display("FAIL frame%0d_fval_seen got 0 cycles want >0", gapped); end
    if (bus.o_fval !== 1'b0) begin miscompares++; $display("FAIL frame%0d_fval_end got %b want 0", gapped, bus.o_fval); end
    if (err_total != e0) begin miscompares++; $display("FAIL frame%0d_err got %0d want 0", gapped, err_total - e0); end
    if (gap_bad != g0) begin miscompares++; $display("FAIL frame%0d_pixv_on_invalid got %0d want 0", gapped, gap_bad - g0); end
    if (lval_bad != l0) begin miscompares++; $display("FAIL frame%0d_lval_qual got %0d want 0", gapped, lval_bad - l0); end
  endtask

  task automatic test_partial_preamble();
    int base = pix_log.size();
    int e0 = err_total;
    logic [PW-1:0] exp_px[6] = '{14'h0001, 14'h0002, 14'h3FFF, 14'h0000, 14'h1234, 14'h0003};
    logic [PW-1:0] got;
    pre(C_SOF, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h1234, 1'b0);
    send(16'h0003, 1'b0);
    pre(C_EOL, 1'b0);
    pre(C_EOF, 1'b0);
    flush(1'b0);
    vectors++;
    if (pix_log.size() - base != 6) begin
      miscompares++;
      $display("FAIL partial_npix got %0d want 6", pix_log.size() - base);
    end
    for (int k = 0; k < 6; k++) begin
      got = (base + k < pix_log.size()) ? pix_log[base + k] : 'x;
      vectors++;
      if (got !== exp_px[k]) begin
        miscompares++;
        $display("FAIL partial_pix%0d got %h want %h", k, got, exp_px[k]);
      end
    end
    vectors += 2;
    if (bus.ov_line_pix_cnt !== CW'(6)) begin miscompares++; $display("FAIL partial_cnt got %0d want 6", bus.ov_line_pix_cnt); end
    if (err_total != e0) begin miscompares++; $display("FAIL partial_err got %0d want 0", err_total - e0); end
  endtask

  task automatic test_max_len();
    int base = pix_log.size();
    int e0 = err_total;
    logic [PW-1:0] got;
    logic [PW-1:0] want;
    bus.iv_max_pix = CW'(8);
    pre(C_SOF, 1'b0);
    for (int i = 1; i <= 10; i++) send(16'(i), 1'b0);
    send(S0, 1'b0);
    send(S1, 1'b0);
    send(S2, 1'b0);
    // Pixel 9 leaves the delay line on this edge and overruns the limit.
    vectors += 3;
    if (bus.o_sync_err !== 1'b1) begin miscompares++; $display("FAIL max_err_pulse got %b want 1", bus.o_sync_err); end
    if (bus.o_lval !== 1'b0) begin miscompares++; $display("FAIL max_gap_lval got %b want 0", bus.o_lval); end
    if (bus.o_fval !== 1'b1) begin miscompares++; $display("FAIL max_gap_fval got %b want 1", bus.o_fval); end
    send(C_SOL, 1'b0);
    send(16'h0021, 1'b0);
    send(16'h0022, 1'b0);
    pre(C_EOL, 1'b0);
    pre(C_EOF, 1'b0);
    flush(1'b0);
    bus.iv_max_pix = '0;
    vectors++;
    if (pix_log.size() - base != 10) begin
      miscompares++;
      $display("FAIL max_npix got %0d want 10", pix_log.size() - base);
    end
    for (int k = 0; k < 10; k++) begin
      want = (k < 8) ? PW'(k + 1) : PW'(16'h0021 + k - 8);
      got = (base + k < pix_log.size()) ? pix_log[base + k] : 'x;
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL max_pix%0d got %h want %h", k, got, want);
      end
    end
    vectors += 2;
    if (err_total - e0 != 1) begin miscompares++; $display("FAIL max_err_count got %0d want 1", err_total - e0); end
    if (bus.ov_line_pix_cnt !== CW'(2)) begin miscompares++; $display("FAIL max_next_cnt got %0d want 2", bus.ov_line_pix_cnt); end
  endtask

  task automatic test_restart_and_reset();
    int base = pix_log.size();
    int e0 = err_total;
    int f0;
    logic [PW-1:0] got;
    pre(C_SOF, 1'b0);
    for (int i = 1; i <= 3; i++) send(16'(i), 1'b0);
    pre(C_SOL, 1'b0);
    send(16'h0004, 1'b0);
    send(16'h0005, 1'b0);
    pre(C_EOL, 1'b0);
    pre(C_EOF, 1'b0);
    flush(1'b0);
    vectors++;
    if (pix_log.size() - base != 5) begin
      miscompares++;
      $display("FAIL restart_npix got %0d want 5", pix_log.size() - base);
    end
    for (int k = 0; k < 5; k++) begin
      got = (base + k < pix_log.size()) ? pix_log[base + k] : 'x;
      vectors++;
      if (got !== PW'(k + 1)) begin
        miscompares++;
        $display("FAIL restart_pix%0d got %h want %h", k, got, PW'(k + 1));
      end
    end
    vectors += 2;
    if (err_total - e0 != 1) begin miscompares++; $display("FAIL restart_err got %0d want 1", err_total - e0); end
    if (bus.ov_line_pix_cnt !== CW'(2)) begin miscompares++; $display("FAIL restart_cnt got %0d want 2", bus.ov_line_pix_cnt); end

    pre(C_SOF, 1'b0);
    for (int i = 1; i <= 6; i++) send(16'(i), 1'b0);
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors += 5;
    if (bus.o_fval !== 1'b0) begin miscompares++; $display("FAIL midreset_fval got %b want 0", bus.o_fval); end
    if (bus.o_lval !== 1'b0) begin miscompares++; $display("FAIL midreset_lval got %b want 0", bus.o_lval); end
    if (bus.o_pix_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_pixv got %b want 0", bus.o_pix_valid); end
    if (bus.ov_pix_data !== '0) begin miscompares++; $display("FAIL midreset_pix got %h want 0", bus.ov_pix_data); end
    if (bus.ov_line_pix_cnt !== '0) begin miscompares++; $display("FAIL midreset_cnt got %0d want 0", bus.ov_line_pix_cnt); end
    @(negedge clk);
    reset = 1'b0;
    base = pix_log.size();
    f0 = fval_hits;
    send(16'h0007, 1'b0);
    send(16'h0008, 1'b0);
    flush(1'b0);
    vectors += 2;
    if (pix_log.size() != base) begin miscompares++; $display("FAIL postreset_npix got %0d want 0", pix_log.size() - base); end
    if (fval_hits != f0) begin miscompares++; $display("FAIL postreset_fval got %0d cycles want 0", fval_hits - f0); end
    pre(C_SOF, 1'b0);
    send(16'h0009, 1'b0);
    pre(C_EOF, 1'b0);
    flush(1'b0);
    got = (base < pix_log.size()) ? pix_log[base] : 'x;
    vectors += 3;
    if (pix_log.size() - base != 1) begin miscompares++; $display("FAIL resync_npix got %0d want 1", pix_log.size() - base); end
    if (got !== 14'h0009) begin miscompares++; $display("FAIL resync_pix got %h want 0009", got); end
    if (bus.ov_line_pix_cnt !== CW'(1)) begin miscompares++; $display("FAIL resync_cnt got %0d want 1", bus.ov_line_pix_cnt); end
  endtask

  task automatic test_illegal_codes();
    int base = pix_log.size();
    int e0 = err_total;
    int f0 = fval_hits;
    logic [PW-1:0] got;
    pre(C_SOL, 1'b0);
    pre(C_EOL, 1'b0);
    pre(C_EOF, 1'b0);
    flush(1'b0);
    vectors += 3;
    if (err_total != e0) begin miscompares++; $display("FAIL idle_err got %0d want 0", err_total - e0); end
    if (fval_hits != f0) begin miscompares++; $display("FAIL idle_fval got %0d cycles want 0", fval_hits - f0); end
    if (pix_log.size() != base) begin miscompares++; $display("FAIL idle_npix got %0d want 0", pix_log.size() - base); end
    pre(C_SOF, 1'b0);
    send(16'h0005, 1'b0);
    pre(C_EOL, 1'b0);
    pre(C_EOL, 1'b0);
    pre(C_EOF, 1'b0);
    flush(1'b0);
    got = (base < pix_log.size()) ? pix_log[base] : 'x;
    vectors += 4;
    if (err_total - e0 != 1) begin miscompares++; $display("FAIL gap_eol_err got %0d want 1", err_total - e0); end
    if (got !== 14'h0005) begin miscompares++; $display("FAIL gap_pix got %h want 0005", got); end
    if (bus.ov_line_pix_cnt !== CW'(1)) begin miscompares++; $display("FAIL gap_cnt got %0d want 1", bus.ov_line_pix_cnt); end
    if (bus.o_fval !== 1'b0) begin miscompares++; $display("FAIL gap_fval_end got %b want 0", bus.o_fval); end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0);
    test_frame(1'b1);
    test_partial_preamble();
    test_max_len();
    test_restart_and_reset();
    test_illegal_codes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ad9970_sync_decoder.md
Name: ad9970_sync_decoder

Overview:
- FPGA-side receiver for the AD9970 LVDS link: takes 16-bit words already deserialized from DOUT0/DOUT1 and locates the embedded synchronization words.
- Strips the sync words and regenerates frame valid, line valid and 14-bit pixel data for the downstream image pipeline.
- Sits directly after the LVDS deserializer/word aligner, in that block's parallel clock domain.

Parameters:
- PIX_WIDTH, 14, pixel bits taken from each data word, iv_data[PIX_WIDTH-1:0].
- CNT_WIDTH, 13, width of the per-line pixel counter and of the max-length limit.

Ports:
- clk  in  1  parallel word clock.
- reset  in  1  asynchronous, active-high reset.
- i_data_valid  in  1  iv_data holds a valid word this cycle.
- iv_data  in  16  deserialized word.
- iv_sync_word0  in  16  preamble word 0.
- iv_sync_word1  in  16  preamble word 1.
- iv_sync_word2  in  16  preamble word 2.
- iv_code_sof  in  16  code word: start of first line of frame.
- iv_code_sol  in  16  code word: start of line.
- iv_code_eol  in  16  code word: end of line.
- iv_code_eof  in  16  code word: end of last line / end of frame.
- iv_max_pix  in  CNT_WIDTH  maximum pixels per line.
- o_fval  out  1  frame valid.
- o_lval  out  1  line valid, qualifies the pixel output.
- o_pix_valid  out  1  ov_pix_data valid strobe.
- ov_pix_data  out  PIX_WIDTH  pixel data.
- ov_line_pix_cnt  out  CNT_WIDTH  pixel count of the last completed line.
- o_sync_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset: all outputs 0, state IDLE, delay line cleared and tagged non-pixel. Reset asserted mid-line aborts the line with no EOL-side effects.
- Registers and pipeline advance only on cycles where i_data_valid=1. Invalid cycles freeze everything and hold o_pix_valid=0.
- Sync sequence: 3 consecutive valid words equal to sync_word0, sync_word1, sync_word2, followed immediately by one code word.
  - A code word matching none of the four codes is not a sync; the preamble words are then treated as ordinary data.
  - Sync words and code words are never emitted as pixels.
- Delay line: 4 valid words deep, so pixel latency is 4 valid words. When a code is detected, the 3 buffered preamble entries are retagged non-pixel.
- FSM states:
  - IDLE (fval=0, lval=0): SOF -> LINE. SOL, EOL and EOF are ignored.
  - LINE (fval=1, lval=1):
    - Each valid data word is emitted (o_pix_valid=1) and increments the pixel counter.
    - EOL -> GAP; latch the count into ov_line_pix_cnt.
    - EOF -> IDLE; latch the count.
    - SOF or SOL -> o_sync_err, restart the line with counter=0, stay in LINE.
    - Counter reaching iv_max_pix with a further pixel arriving -> o_sync_err, drop that pixel, go to GAP.
  - GAP (fval=1, lval=0): SOL -> LINE; EOF -> IDLE; SOF -> o_sync_err then LINE; EOL -> o_sync_err, stay in GAP. Data words in GAP are discarded.
- Output timing: o_fval and o_lval are aligned with the delayed pixel stream. lval rises together with the first pixel's o_pix_valid and falls in the cycle after the last pixel.
- Counter saturates at all-ones. A zero-length line (SOL then EOL with no data) latches 0 and raises no error.
- iv_max_pix = 0 disables the length check.

Test Plan:
- Preamble FFFF,0000,0000 with SOF=8000; 10 pixels 0x0001..0x000A; preamble+EOL=9D00; then preamble+EOF=B600 -> fval high for the frame; exactly 10 o_pix_valid pulses carrying 1..10; first pixel 4 valid words after input; ov_line_pix_cnt=10; no sync word appears on the output.
- Same frame with i_data_valid=0 on every other cycle -> identical pixel sequence and count; o_pix_valid never high while i_data_valid is low.
- Partial preamble FFFF,0000,1234 inside a line -> all three emitted as pixels (0000, 1234 low 14 bits); no state change.
- iv_max_pix=8 with a 10-pixel line -> 8 pixels out, o_sync_err pulses once, state GAP, next SOL starts a clean line.
- SOL while in LINE -> o_sync_err pulse and counter restarts; reset asserted mid-line -> all outputs 0 next cycle, SOF required to restart.
- EOL while in GAP, and SOL/EOF while IDLE -> EOL in GAP gives one o_sync_err pulse; IDLE codes are ignored with no error; fval stays 0 in IDLE.
